// File: rtl/addsub_mul_unit.sv
// Registered add/sub/slt/multiply unit with start/done handshake.
// ALU ops complete in one cycle; the shift-add multiply takes WIDTH cycles.
module addsub_mul_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rx,
  input  logic [WIDTH-1:0] ry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpSlt = 2'b11;

  typedef enum logic [1:0] {StIdle, StAlu, StMul} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   data_out_q;
  logic               done_q, zero_q, negative_q, carry_q, overflow_q;

  logic               accept, last_iter, complete;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic               sum_ovf, slt_bit;
  logic [2*WIDTH-1:0] partial, acc_next;
  logic [WIDTH-1:0]   res;
  logic               res_carry, res_ovf;

  assign accept    = start && (state_q == StIdle);
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));
  assign complete  = (state_q == StAlu) || ((state_q == StMul) && last_iter);

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (op == OpMul) ? StMul : StAlu;
      StAlu:   state_d = StIdle;
      StMul:   if (last_iter) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Sub and slt both use rx + ~ry + 1; slt is sign XOR overflow of that difference.
  always_comb begin
    b_eff    = (op_q == OpAdd) ? b_q : ~b_q;
    sum      = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_q != OpAdd)};
    sum_ovf  = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    slt_bit  = sum[WIDTH-1] ^ sum_ovf;
    partial  = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    acc_next = acc_q + partial;
  end

  always_comb begin
    res       = sum[WIDTH-1:0];
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    unique case (op_q)
      OpAdd, OpSub: begin
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        res_ovf   = sum_ovf;
      end
      OpMul: begin
        res     = acc_next[WIDTH-1:0];
        res_ovf = |acc_next[2*WIDTH-1:WIDTH];
      end
      OpSlt: res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OpAdd;
      acc_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= complete;
      if (accept) begin
        a_q   <= rx;
        b_q   <= ry;
        op_q  <= op;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == StMul) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + CntW'(1);
      end
      if (complete) begin
        data_out_q <= res;
        zero_q     <= (res == '0);
        negative_q <= res[WIDTH-1];
        carry_q    <= res_carry;
        overflow_q <= res_ovf;
      end
    end
  end

  assign done     = done_q;
  assign data_out = data_out_q;
  assign zero     = zero_q;
  assign negative = negative_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_addsub_mul_unit.sv
// Directed self-checking bench for addsub_mul_unit at WIDTH=16.
module tb_addsub_mul_unit;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] rx = '0;
  logic [15:0] ry = '0;
  logic        busy, done, zero, negative, carry, overflow;
  logic [15:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int lat;
  int dcount;

  addsub_mul_unit #(.WIDTH(16)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .start    (start),
    .op       (op),
    .rx       (rx),
    .ry       (ry),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation and return once done is seen (sampled 1 time unit after each edge).
  task automatic run(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                     output int latency);
    @(negedge Clock);
    start = 1'b1; op = o; rx = a; ry = b;
    @(posedge Clock); #1;
    @(negedge Clock);
    start = 1'b0;
    latency = 0;
    while (!done && latency < 40) begin
      @(posedge Clock); #1;
      latency++;
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, zero, negative, carry, overflow};
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst data", data_out, 0);
    chk("rst flags", flags(), 0);
    @(negedge Clock);
    Resetn = 1'b1;

    run(2'b00, 16'h0005, 16'h0003, lat);
    chk("add1 lat", lat, 1);
    chk("add1 data", data_out, 16'h0008);
    chk("add1 flags", flags(), 4'b0000);
    chk("add1 busy", busy, 0);

    run(2'b00, 16'hFFFF, 16'h0001, lat);
    chk("add2 data", data_out, 16'h0000);
    chk("add2 flags zncv", flags(), 4'b1010);

    run(2'b01, 16'h0003, 16'h0005, lat);
    chk("sub lat", lat, 1);
    chk("sub data", data_out, 16'hFFFE);
    chk("sub flags zncv", flags(), 4'b0100);

    run(2'b00, 16'h7FFF, 16'h0001, lat);
    chk("addovf data", data_out, 16'h8000);
    chk("addovf flags zncv", flags(), 4'b0101);

    run(2'b10, 16'h0012, 16'h0034, lat);
    chk("mul1 lat", lat, 16);
    chk("mul1 data", data_out, 16'h03A8);
    chk("mul1 flags zncv", flags(), 4'b0000);

    run(2'b10, 16'h0100, 16'h0100, lat);
    chk("mul2 lat", lat, 16);
    chk("mul2 data", data_out, 16'h0000);
    chk("mul2 flags zncv", flags(), 4'b1001);

    run(2'b11, 16'hFFFF, 16'h0001, lat);
    chk("slt1 lat", lat, 1);
    chk("slt1 data", data_out, 16'h0001);
    chk("slt1 flags zncv", flags(), 4'b0000);

    run(2'b11, 16'h0001, 16'hFFFF, lat);
    chk("slt2 data", data_out, 16'h0000);
    chk("slt2 flags zncv", flags(), 4'b1000);

    // Start held high through a mul while operands and op change
    @(negedge Clock);
    start = 1'b1; op = 2'b10; rx = 16'h0003; ry = 16'h0005;
    @(posedge Clock); #1;
    chk("hold busy", busy, 1);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      op = 2'b00; rx = 16'h0007 + 16'(i); ry = 16'h0009;
      @(posedge Clock); #1;
      if (done) dcount++;
    end
    @(negedge Clock);
    start = 1'b0;
    lat = 10;
    while (!done && lat < 40) begin
      @(posedge Clock); #1;
      lat++;
    end
    dcount++;
    chk("hold lat", lat, 16);
    chk("hold data", data_out, 16'h000F);
    repeat (5) begin
      @(posedge Clock); #1;
      if (done) dcount++;
    end
    chk("hold done count", dcount, 1);

    // Back-to-back: new start raised in the done cycle
    run(2'b00, 16'h0010, 16'h0020, lat);
    chk("b2b first data", data_out, 16'h0030);
    start = 1'b1; op = 2'b00; rx = 16'h0002; ry = 16'h0002;
    @(posedge Clock); #1;
    chk("b2b accepted busy", busy, 1);
    @(negedge Clock);
    start = 1'b0;
    @(posedge Clock); #1;
    chk("b2b done", done, 1);
    chk("b2b data", data_out, 16'h0004);

    // Asynchronous reset during mul iteration 8
    @(negedge Clock);
    start = 1'b1; op = 2'b10; rx = 16'h0003; ry = 16'h0003;
    @(posedge Clock); #1;
    @(negedge Clock);
    start = 1'b0;
    repeat (8) @(posedge Clock);
    #3;
    Resetn = 1'b0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst data", data_out, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(posedge Clock); #1;
      if (done) dcount++;
    end
    chk("arst no done", dcount, 0);

    run(2'b00, 16'h0001, 16'h0001, lat);
    chk("post-rst lat", lat, 1);
    chk("post-rst data", data_out, 16'h0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addsub_mul_unit.md
Name: addsub_mul_unit

Overview:
Parametrised, registered arithmetic unit for the datapath. It is the successor to the combinational add/sub block. It adds a start/done handshake, a multi-cycle shift-add multiply, signed set-less-than, and status flags, at configurable width. The control FSM issues one operation at a time and waits for done before reading data_out and the flags.

Parameters:
WIDTH, 16, operand and result width in bits; legal range 4..32.

Ports:
Clock  input  1  rising-edge system clock
Resetn  input  1  asynchronous active-low reset
start  input  1  request operation; sampled only when busy=0
op  input  2  00 add, 01 sub, 10 mul (unsigned), 11 slt (signed)
rx  input  WIDTH  operand A; latched at acceptance
ry  input  WIDTH  operand B; latched at acceptance
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result and flags valid
data_out  output  WIDTH  result; held until the next done
zero  output  1  data_out == 0
negative  output  1  data_out[WIDTH-1]
carry  output  1  add: carry-out; sub: no-borrow (carry-out of rx + ~ry + 1); else 0
overflow  output  1  add/sub: signed overflow; mul: upper product bits nonzero; slt: 0

Behaviour:
- Reset (Resetn=0, asynchronous): FSM goes to IDLE; busy=0, done=0, data_out=0. Flags reset to 0, including zero (registered, not derived).
- Reset mid-operation: aborts the operation; no done pulse, and the partial result is discarded.
- FSM states: IDLE, ALU, MUL.
- Acceptance: start=1 with busy=0 at rising edge k.
  - rx, ry and op are latched and busy goes to 1.
  - Next state: ALU for op 00/01/11, MUL for op 10.
- Changes to rx, ry or op after edge k have no effect on the running operation.
- start=1 while busy=1 is ignored; it is neither queued nor an error.
- ALU state, one cycle:
  - At edge k+1, data_out and flags are registered, done=1 and busy=0; next state IDLE.
  - Latency: done is visible in the cycle after edge k+1.
- Add: result = (rx + ry) mod 2^WIDTH.
- Sub: result = rx + ~ry + 1, same width rule as add.
- Signed overflow (add/sub): operand sign bits agree (for sub, compare rx with ~ry) and the result sign differs.
- Slt: data_out = 1 if $signed(rx) < $signed(ry), else 0. Derived from the sub result: sign XOR overflow.
- MUL state, WIDTH iterations:
  - Internal 2*WIDTH-bit accumulator and an iteration counter, both cleared at acceptance.
  - Iteration i (edge k+1+i, i = 0..WIDTH-1): if ry_latched[i]=1, add rx_latched << i.
  - At edge k+WIDTH the final iteration completes. In that same edge, data_out = product[WIDTH-1:0], overflow = |product[2*WIDTH-1:WIDTH], carry=0, done=1, busy=0.
  - Latency: WIDTH cycles.
- Flags: zero and negative are always computed from the new data_out. All flags update only on done edges.
- done is high exactly one cycle and never coincides with busy=1.
- Back-to-back: start=1 in the done cycle is accepted (busy=0), so the done edge itself is edge k of the next operation.
- Operands rx=0 or ry=0: mul still takes WIDTH cycles (fixed latency, no early exit).
- Widths: all internal arithmetic is WIDTH+1 bits for carry and 2*WIDTH bits for the product. No implicit truncation before the flags are computed.

Test Plan:
(all with WIDTH=16)
- Add: op=00, rx=0x0005, ry=0x0003, start one cycle -> done one cycle after acceptance; data_out=0x0008, all flags 0. Add: rx=0xFFFF, ry=0x0001 -> data_out=0x0000, zero=1, carry=1, overflow=0.
- Sub/overflow: op=01, rx=0x0003, ry=0x0005 -> data_out=0xFFFE, negative=1, carry=0. op=00, rx=0x7FFF, ry=0x0001 -> data_out=0x8000, overflow=1, negative=1.
- Mul: op=10, rx=0x0012, ry=0x0034 -> done exactly 16 cycles after acceptance; data_out=0x03A8, overflow=0. Mul: rx=0x0100, ry=0x0100 -> data_out=0x0000, zero=1, overflow=1.
- Slt: op=11, rx=0xFFFF, ry=0x0001 -> data_out=0x0001. Swapped operands -> data_out=0x0000, zero=1.
- Handshake:
  - start held high during a mul, with rx and ry changed mid-operation -> result unaffected and one done only.
  - start=1 in the done cycle (add 0x0002+0x0002) -> accepted; data_out=0x0004 after one further cycle.
- Reset: assert Resetn=0 asynchronously (mid-clock) during mul iteration 8 -> busy, done and data_out go to 0 immediately; no done pulse afterwards. The next add after release (0x0001+0x0001) -> 0x0002.
